// File: rtl/vga_stream_gen.sv
// VGA timing and pixel stream source: free-running raster counters, a pixel request port
// into a 1-cycle-latency frame source, and a two-stage output pipeline with optional test pattern.
module vga_stream_gen #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int H_SYNC_CYC   = 96,
    parameter int H_SYNC_BACK  = 48,
    parameter int H_SYNC_FRONT = 16,
    parameter int V_SYNC_CYC   = 2,
    parameter int V_SYNC_BACK  = 33,
    parameter int V_SYNC_FRONT = 10
) (
    input  logic        VGA_CLK,
    input  logic        reset_n,
    input  logic        pattern_en,
    output logic        req_valid,
    output logic [12:0] req_x,
    output logic [12:0] req_y,
    input  logic [7:0]  src_R,
    input  logic [7:0]  src_G,
    input  logic [7:0]  src_B,
    output logic [7:0]  oVGA_R,
    output logic [7:0]  oVGA_G,
    output logic [7:0]  oVGA_B,
    output logic        oVGA_HS,
    output logic        oVGA_VS,
    output logic        oVGA_SYNC_N,
    output logic        oVGA_BLANK_N,
    output logic [15:0] frame_count,
    output logic        frame_start
);

    localparam int H_BLANK_I = H_SYNC_FRONT + H_SYNC_CYC + H_SYNC_BACK;
    localparam int V_BLANK_I = V_SYNC_FRONT + V_SYNC_CYC + V_SYNC_BACK;
    localparam int H_TOTAL_I = H_BLANK_I + WIDTH;
    localparam int V_TOTAL_I = V_BLANK_I + HEIGHT;

    localparam logic [12:0] H_BLANK  = 13'(H_BLANK_I);
    localparam logic [12:0] V_BLANK  = 13'(V_BLANK_I);
    localparam logic [12:0] H_LAST   = 13'(H_TOTAL_I - 1);
    localparam logic [12:0] V_LAST   = 13'(V_TOTAL_I - 1);
    localparam logic [12:0] HS_START = 13'(H_SYNC_FRONT);
    localparam logic [12:0] HS_END   = 13'(H_SYNC_FRONT + H_SYNC_CYC);
    localparam logic [12:0] VS_START = 13'(V_SYNC_FRONT);
    localparam logic [12:0] VS_END   = 13'(V_SYNC_FRONT + V_SYNC_CYC);

    // Stage 1 carries the timing of the pixel whose source data is arriving this cycle.
    typedef struct packed {
        logic       blank_n;
        logic       hs;
        logic       vs;
        logic       sof;
        logic       pat;
        logic [7:0] x;
        logic [7:0] y;
    } stage1_t;

    typedef struct packed {
        logic       blank_n;
        logic       hs;
        logic       vs;
        logic       frame_start;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } stage2_t;

    localparam stage1_t S1_IDLE = '{blank_n: 1'b0, hs: 1'b1, vs: 1'b1, sof: 1'b0,
                                    pat: 1'b0, x: 8'd0, y: 8'd0};
    localparam stage2_t S2_IDLE = '{blank_n: 1'b0, hs: 1'b1, vs: 1'b1, frame_start: 1'b0,
                                    r: 8'd0, g: 8'd0, b: 8'd0};

    logic [12:0] h_cnt_q, h_cnt_d;
    logic [12:0] v_cnt_q, v_cnt_d;
    stage1_t     s1_q, s1_d;
    stage2_t     s2_q, s2_d;
    logic [15:0] frame_count_q, frame_count_d;
    logic        started_q, started_d;
    logic [7:0]  pat_sum;

    always_comb begin
        req_valid = (h_cnt_q >= H_BLANK) && (v_cnt_q >= V_BLANK);
        req_x     = req_valid ? h_cnt_q - H_BLANK : 13'd0;
        req_y     = req_valid ? v_cnt_q - V_BLANK : 13'd0;
    end

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned
        // and no latch is inferred.
        h_cnt_d       = h_cnt_q + 13'd1;
        v_cnt_d       = v_cnt_q;
        s1_d          = S1_IDLE;
        s2_d          = S2_IDLE;
        frame_count_d = frame_count_q;
        started_d     = started_q;
        pat_sum       = s1_q.x + s1_q.y;

        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 13'd0;
            v_cnt_d = (v_cnt_q == V_LAST) ? 13'd0 : v_cnt_q + 13'd1;
        end

        s1_d.blank_n = req_valid;
        s1_d.hs      = !((h_cnt_q > HS_START) && (h_cnt_q <= HS_END));
        s1_d.vs      = !((v_cnt_q > VS_START) && (v_cnt_q <= VS_END));
        s1_d.sof     = (h_cnt_q == 13'd0) && (v_cnt_q == 13'd0);
        s1_d.pat     = pattern_en;
        s1_d.x       = req_x[7:0];
        s1_d.y       = req_y[7:0];

        s2_d.blank_n     = s1_q.blank_n;
        s2_d.hs          = s1_q.hs;
        s2_d.vs          = s1_q.vs;
        s2_d.frame_start = s1_q.sof;
        if (s1_q.blank_n) begin
            if (s1_q.pat) begin
                s2_d.r = s1_q.x;
                s2_d.g = s1_q.y;
                s2_d.b = pat_sum;
            end else begin
                s2_d.r = src_R;
                s2_d.g = src_G;
                s2_d.b = src_B;
            end
        end

        // The very first frame after reset is not a completed frame, so it is not counted.
        if (s1_q.sof) begin
            started_d = 1'b1;
            if (started_q) begin
                frame_count_d = frame_count_q + 16'd1;
            end
        end

        if (!reset_n) begin
            h_cnt_d       = 13'd0;
            v_cnt_d       = 13'd0;
            s1_d          = S1_IDLE;
            s2_d          = S2_IDLE;
            frame_count_d = 16'd0;
            started_d     = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge VGA_CLK) begin
        h_cnt_q       <= h_cnt_d;
        v_cnt_q       <= v_cnt_d;
        s1_q          <= s1_d;
        s2_q          <= s2_d;
        frame_count_q <= frame_count_d;
        started_q     <= started_d;
    end

    assign oVGA_R       = s2_q.r;
    assign oVGA_G       = s2_q.g;
    assign oVGA_B       = s2_q.b;
    assign oVGA_HS      = s2_q.hs;
    assign oVGA_VS      = s2_q.vs;
    assign oVGA_BLANK_N = s2_q.blank_n;
    assign oVGA_SYNC_N  = 1'b0;
    assign frame_start  = s2_q.frame_start;
    assign frame_count  = frame_count_q;

endmodule
